captura_operandos: RTL and testbench

CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

---
 rtl/calc_pkg.sv | 18 +
 rtl/debounce_botao.sv | 58 +++++
 rtl/captura_operandos.sv | 101 ++++++++++
 tb/tb_captura_operandos.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared codes for the operand-capture front end and the calculator datapath.
package calc_pkg;

  typedef enum logic [1:0] {
    ESPERA_A  = 2'b00,
    ESPERA_B  = 2'b01,
    ESPERA_OP = 2'b10,
    PRONTO    = 2'b11
  } estado_t;

  localparam logic [1:0] OP_SOMA = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/debounce_botao.sv
// Raw button -> 2-flop sync -> counting debouncer -> registered one-cycle press pulse.
// Pulse appears in the cycle after edge DEBOUNCE_CYCLES+2 when raw is held from edge 0.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        level_q, level_d;
  logic        level_dly_q, level_dly_d;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = raw_i;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = 16'd0;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    // Any sample agreeing with the current level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/captura_operandos.sv
// Captures A, B and the operation code from switches on debounced ok presses; clr resets the sequence.
module captura_operandos
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       btn_ok,
  input  logic       btn_clr,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [1:0] sel,
  output logic       valid,
  output logic       div_zero,
  output logic [1:0] estado
);

  logic ok_press;
  logic clr_press;

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_ok),
    .press_o (ok_press)
  );

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_clr),
    .press_o (clr_press)
  );

  estado_t    state_q, state_d;
  logic [2:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    // clr has priority over a coincident ok press.
    if (clr_press) begin
      state_d = ESPERA_A;
      a_d     = 3'd0;
      b_d     = 3'd0;
      sel_d   = OP_SOMA;
    end else if (ok_press) begin
      case (state_q)
        ESPERA_A: begin
          a_d     = sw;
          state_d = ESPERA_B;
        end
        ESPERA_B: begin
          b_d     = sw;
          state_d = ESPERA_OP;
        end
        ESPERA_OP: begin
          sel_d   = sw[1:0];
          state_d = PRONTO;
        end
        PRONTO: begin
          a_d     = sw;
          state_d = ESPERA_B;
        end
        default: state_d = ESPERA_A;
      endcase
    end
    valid_d = (state_d == PRONTO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ESPERA_A;
      a_q     <= 3'd0;
      b_q     <= 3'd0;
      sel_q   <= OP_SOMA;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign sel      = sel_q;
  assign valid    = valid_q;
  assign estado   = state_q;
  assign div_zero = valid_q && (sel_q == OP_DIV) && (b_q == 3'd0);

endmodule

// File: tb/tb_captura_operandos.sv
// Randomized and directed checks of captura_operandos against an operation-level model.
module tb_captura_operandos;

  localparam int N    = 4;
  localparam int HOLD = N + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw = 3'd0;
  logic       btn_ok = 1'b0;
  logic       btn_clr = 1'b0;
  logic [2:0] A, B;
  logic [1:0] sel;
  logic       valid, div_zero;
  logic [1:0] estado;

  int total = 0;
  int bad   = 0;

  // Model: number of operands captured so far in the current operation.
  int m_a = 0, m_b = 0, m_sel = 0, m_stage = 0;

  captura_operandos #(.DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_ok   (btn_ok),
    .btn_clr  (btn_clr),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .valid    (valid),
    .div_zero (div_zero),
    .estado   (estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_sel = 0; m_stage = 0;
  endtask

  task automatic model_event(input bit ok, input bit clr, input int v);
    if (clr) begin
      model_reset();
    end else if (ok) begin
      if (m_stage == 0 || m_stage == 3) begin
        m_a = v; m_stage = 1;
      end else if (m_stage == 1) begin
        m_b = v; m_stage = 2;
      end else begin
        m_sel = v % 4; m_stage = 3;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_valid;
    exp_valid = (m_stage == 3);
    chk({tag, ".A"}, int'(A), m_a);
    chk({tag, ".B"}, int'(B), m_b);
    chk({tag, ".sel"}, int'(sel), m_sel);
    chk({tag, ".valid"}, int'(valid), int'(exp_valid));
    chk({tag, ".div_zero"}, int'(div_zero), int'(exp_valid && m_sel == 3 && m_b == 0));
    chk({tag, ".estado"}, int'(estado), m_stage);
  endtask

  // Clean press and release of one or both buttons, then a model update.
  task automatic press(input bit ok, input bit clr, input logic [2:0] v);
    @(negedge clk);
    sw = v; btn_ok = ok; btn_clr = clr;
    repeat (HOLD) @(negedge clk);
    btn_ok = 1'b0; btn_clr = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_event(ok, clr, int'(v));
  endtask

  // Raw btn_ok goes high just before edge 0; returns pulse count and edge index of the last pulse.
  task automatic watch_ok_pulse(output int n_pulse, output int at_edge);
    n_pulse = 0; at_edge = -1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (dut.u_ok.press_o) begin
        n_pulse++; at_edge = k;
      end
    end
  endtask

  initial begin
    int np, at;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all("post_reset");

    // Clean entry 5, 3, product
    press(1, 0, 3'd5); check_all("entry_a");
    press(1, 0, 3'd3); check_all("entry_b");
    press(1, 0, 3'd2); check_all("entry_op");
    chk("entry.valid_lit", int'(valid), 1);
    chk("entry.sel_lit", int'(sel), 2);

    // Bounce rejection from a fresh ESPERA_A
    press(0, 1, 3'd0); check_all("clr1");
    @(negedge clk);
    sw = 3'd6;
    for (int h = 0; h < 10; h++) begin
      btn_ok = (h % 2 == 0);
      repeat (2) @(negedge clk);
    end
    chk("bounce.no_early_pulse", int'(estado), 0);
    btn_ok = 1'b1;
    watch_ok_pulse(np, at);
    chk("bounce.pulse_count", np, 1);
    chk("bounce.pulse_edge", at, N + 2);
    model_event(1, 0, 6);
    @(negedge clk);
    btn_ok = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_all("bounce_capture");

    // Divide by zero, then a new operation from PRONTO
    press(0, 1, 3'd0);
    press(1, 0, 3'd6);
    press(1, 0, 3'd0);
    press(1, 0, 3'd3); check_all("divzero");
    chk("divzero.flag_lit", int'(div_zero), 1);
    press(1, 0, 3'd4); check_all("divzero_next");
    chk("divzero_next.estado_lit", int'(estado), 1);

    // Coincident ok and clr in ESPERA_OP
    press(0, 1, 3'd0);
    press(1, 0, 3'd7);
    press(1, 0, 3'd1);
    chk("prio.pre_estado", int'(estado), 2);
    press(1, 1, 3'd2); check_all("prio");

    // Held held-button: a second pulse needs a release
    @(negedge clk);
    sw = 3'd1; btn_ok = 1'b1;
    repeat (4 * HOLD) @(negedge clk);
    model_event(1, 0, 1);
    check_all("held_once");
    btn_ok = 1'b0;
    repeat (HOLD) @(negedge clk);

    // Randomized sequences of presses, clears and idle switch changes
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        press(1, 0, 3'($urandom_range(0, 7)));
      end else if (r == 7) begin
        press(0, 1, 3'($urandom_range(0, 7)));
      end else begin
        @(negedge clk);
        sw = 3'($urandom_range(0, 7));
        repeat (HOLD) @(negedge clk);
      end
      check_all($sformatf("rand%0d", it));
    end

    // Async reset from PRONTO, with btn_ok held through release
    press(0, 1, 3'd0);
    press(1, 0, 3'd2);
    press(1, 0, 3'd5);
    press(1, 0, 3'd1);
    chk("arst.pre_valid", int'(valid), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst_now");
    sw = 3'd3; btn_ok = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    watch_ok_pulse(np, at);
    chk("arst.pulse_count", np, 1);
    chk("arst.pulse_edge", at, N + 2);
    model_event(1, 0, 3);
    @(negedge clk);
    btn_ok = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_all("arst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
